// File: rtl/mdu_pkg.sv
// mdu_pkg: shared operation encodings, FSM state type and default sizes
// for the iterative multiply/divide unit.
package mdu_pkg;

  // Default operand / HI / LO width and iteration counter width.
  localparam int MDU_WIDTH    = 32;
  localparam int MDU_CNT_BITS = 6;

  // Operation encodings as presented on the op port.
  localparam logic [1:0] MDU_OP_MULTU = 2'b00;
  localparam logic [1:0] MDU_OP_DIVU  = 2'b01;
  localparam logic [1:0] MDU_OP_MULT  = 2'b10;
  localparam logic [1:0] MDU_OP_DIV   = 2'b11;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MUL    = 2'd1,
    ST_DIV    = 2'd2,
    ST_FINISH = 2'd3
  } mdu_state_e;

endpackage

// File: rtl/mdu_iter_step.sv
// mdu_iter_step: one radix-2 iteration of the multiply/divide loop.
// Multiply: adds the multiplicand when the current multiplier bit is set,
// then shifts the sum right by one; the bit falling out becomes the next
// product bit for the low half.
// Divide: shifts the next dividend bit into the partial remainder and
// subtracts the divisor when it fits (restoring division); the fit flag is
// the quotient bit.
module mdu_iter_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic [WIDTH-1:0] i_partial,
  input  logic [WIDTH-1:0] i_operand,
  input  logic             i_ctrlBit,
  input  logic             i_isDiv,
  output logic [WIDTH-1:0] o_partial,
  output logic             o_bit
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shifted;
  logic [WIDTH-1:0] w_diff;
  logic             w_fits;

  // Compute both candidate next partials and select by mode.
  always_comb begin
    w_sum     = {1'b0, i_partial} + (i_ctrlBit ? {1'b0, i_operand} : '0);
    w_shifted = {i_partial, i_ctrlBit};
    w_fits    = (w_shifted >= {1'b0, i_operand});
    w_diff    = w_shifted[WIDTH-1:0] - i_operand;
    if (i_isDiv) begin
      o_partial = w_fits ? w_diff : w_shifted[WIDTH-1:0];
      o_bit     = w_fits;
    end else begin
      o_partial = w_sum[WIDTH:1];
      o_bit     = w_sum[0];
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative HI/LO multiply/divide unit, one result bit per
// clock. Results remain in HI/LO until overwritten by a new operation or by
// the MTHI/MTLO write strobes (accepted only while idle).
// Configuration macro MDU_SIGNED_EN: when defined, op[1] selects signed
// MULT/DIV handling; when undefined all operations are unsigned and no sign
// logic is built.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH    = MDU_WIDTH,
  parameter int CNT_BITS = MDU_CNT_BITS
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_operand_a,
  input  logic [WIDTH-1:0] i_operand_b,
  input  logic             i_hi_we,
  input  logic             i_lo_we,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  // Counter value of the final iteration; CNT_BITS must be able to hold it.
  localparam logic [CNT_BITS-1:0] LAST_CNT = CNT_BITS'(WIDTH - 1);

  mdu_state_e          r_state;
  logic [CNT_BITS-1:0] r_cnt;
  logic [WIDTH-1:0]    r_acc;
  logic [WIDTH-1:0]    r_shift;
  logic [WIDTH-1:0]    r_operand;
  logic [WIDTH-1:0]    r_hi;
  logic [WIDTH-1:0]    r_lo;
  logic                r_busy;
  logic                r_done;

  mdu_state_e          w_reqState;
  logic [WIDTH-1:0]    w_absA;
  logic [WIDTH-1:0]    w_absB;
  logic                w_stepIsDiv;
  logic                w_stepCtrl;
  logic [WIDTH-1:0]    w_stepPartial;
  logic                w_stepBit;
  logic [WIDTH-1:0]    w_finHi;
  logic [WIDTH-1:0]    w_finLo;

`ifdef MDU_SIGNED_EN
  logic                r_negLo;
  logic                r_negHi;
  logic                r_isDiv;
  logic                w_signReq;
  logic                w_aNeg;
  logic                w_bNeg;
  logic                w_negLoReq;
  logic                w_negHiReq;
  logic [2*WIDTH-1:0]  w_prodNeg;
`endif

  // Decode the request: target loop state, operand magnitudes and the
  // signs the result will need once the unsigned loop has finished.
  always_comb begin
    case (i_op)
      MDU_OP_MULTU, MDU_OP_MULT: w_reqState = ST_MUL;
      MDU_OP_DIVU, MDU_OP_DIV:   w_reqState = ST_DIV;
      default:                   w_reqState = ST_MUL;
    endcase
`ifdef MDU_SIGNED_EN
    w_signReq = (i_op == MDU_OP_MULT) || (i_op == MDU_OP_DIV);
    w_aNeg    = w_signReq & i_operand_a[WIDTH-1];
    w_bNeg    = w_signReq & i_operand_b[WIDTH-1];
    w_absA    = w_aNeg ? (~i_operand_a + WIDTH'(1)) : i_operand_a;
    w_absB    = w_bNeg ? (~i_operand_b + WIDTH'(1)) : i_operand_b;
    if (w_reqState == ST_DIV) begin
      // A zero divisor must leave the all-ones quotient un-negated so the
      // remainder path alone restores the original dividend into HI.
      w_negLoReq = (w_aNeg ^ w_bNeg) & (i_operand_b != '0);
      w_negHiReq = w_aNeg;
    end else begin
      w_negLoReq = w_aNeg ^ w_bNeg;
      w_negHiReq = w_aNeg ^ w_bNeg;
    end
`else
    w_absA = i_operand_a;
    w_absB = i_operand_b;
`endif
  end

  // The multiplier is consumed from its LSB, the dividend from its MSB.
  assign w_stepIsDiv = (r_state == ST_DIV);
  assign w_stepCtrl  = w_stepIsDiv ? r_shift[WIDTH-1] : r_shift[0];

  mdu_iter_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_partial (r_acc),
    .i_operand (r_operand),
    .i_ctrlBit (w_stepCtrl),
    .i_isDiv   (w_stepIsDiv),
    .o_partial (w_stepPartial),
    .o_bit     (w_stepBit)
  );

  // Apply sign correction to the unsigned loop result before it is written.
  always_comb begin
`ifdef MDU_SIGNED_EN
    w_prodNeg = ~{r_acc, r_shift} + (2*WIDTH)'(1);
    if (r_isDiv) begin
      w_finHi = r_negHi ? (~r_acc + WIDTH'(1)) : r_acc;
      w_finLo = r_negLo ? (~r_shift + WIDTH'(1)) : r_shift;
    end else if (r_negLo) begin
      w_finHi = w_prodNeg[2*WIDTH-1:WIDTH];
      w_finLo = w_prodNeg[WIDTH-1:0];
    end else begin
      w_finHi = r_acc;
      w_finLo = r_shift;
    end
`else
    w_finHi = r_acc;
    w_finLo = r_shift;
`endif
  end

  // Sequencer: accept requests and direct writes in IDLE, run one loop
  // iteration per clock, then publish HI/LO with a one-cycle done pulse.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_acc     <= '0;
      r_shift   <= '0;
      r_operand <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef MDU_SIGNED_EN
      r_negLo   <= 1'b0;
      r_negHi   <= 1'b0;
      r_isDiv   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_hi_we) begin
            r_hi <= i_wr_data;
          end
          if (i_lo_we) begin
            r_lo <= i_wr_data;
          end
          if (i_start) begin
            r_acc     <= '0;
            r_shift   <= w_absA;
            r_operand <= w_absB;
            r_cnt     <= '0;
            r_busy    <= 1'b1;
            r_state   <= w_reqState;
`ifdef MDU_SIGNED_EN
            r_negLo   <= w_negLoReq;
            r_negHi   <= w_negHiReq;
            r_isDiv   <= (w_reqState == ST_DIV);
`endif
          end
        end
        ST_MUL: begin
          r_acc   <= w_stepPartial;
          r_shift <= {w_stepBit, r_shift[WIDTH-1:1]};
          r_cnt   <= r_cnt + CNT_BITS'(1);
          if (r_cnt == LAST_CNT) begin
            r_state <= ST_FINISH;
          end
        end
        ST_DIV: begin
          r_acc   <= w_stepPartial;
          r_shift <= {r_shift[WIDTH-2:0], w_stepBit};
          r_cnt   <= r_cnt + CNT_BITS'(1);
          if (r_cnt == LAST_CNT) begin
            r_state <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          r_hi    <= w_finHi;
          r_lo    <= w_finLo;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule
